// File: rtl/turbo_puncture_packer.sv
// Turbo encoder output stage: optional rate-1/2 puncturing, LSB-first byte packing
// and a first-word-fall-through byte FIFO with a last-byte-of-frame marker.
module turbo_puncture_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter bit PUNCTURE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sym_in,
    input  logic       sym_valid,
    input  logic       sym_last,
    output logic       sym_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [9:0]    acc_q, acc_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          phase_q, phase_d;
    logic          flush_q, flush_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic       accept, push_req, push, pop, full, push_last;
    logic [2:0] new_bits;
    logic [3:0] n_bits;

    assign sym_ready = !rst && (bit_cnt_q < 4'd8) && !flush_q;
    assign accept    = sym_valid && sym_ready;
    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push_req  = (bit_cnt_q >= 4'd8);
    // A full FIFO still takes the pending byte when the head leaves in the same cycle.
    assign push      = push_req && (!full || pop);
    assign push_last = flush_q && (bit_cnt_q == 4'd8);

    assign out_byte  = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign out_last  = out_valid ? mem_q[rd_ptr_q][8] : 1'b0;

    always_comb begin
        new_bits = '0;
        n_bits   = 4'd0;
        if (PUNCTURE_EN) begin
            new_bits = {1'b0, (phase_q ? sym_in[0] : sym_in[1]), sym_in[2]};
            n_bits   = 4'd2;
        end else begin
            new_bits = {sym_in[0], sym_in[1], sym_in[2]};
            n_bits   = 4'd3;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        flush_d   = flush_q;
        if (accept) begin
            acc_d     = acc_q | ({7'b0, new_bits} << bit_cnt_q);
            bit_cnt_d = bit_cnt_q + n_bits;
            phase_d   = sym_last ? 1'b0 : ~phase_q;
            flush_d   = flush_q | sym_last;
        end else if (push) begin
            acc_d     = acc_q >> 8;
            bit_cnt_d = bit_cnt_q - 4'd8;
        end else if (flush_q) begin
            // Bits above bit_cnt are already zero, so jumping to 8 zero-pads the byte.
            if (bit_cnt_q == 4'd0) begin
                flush_d = 1'b0;
            end else if (bit_cnt_q < 4'd8) begin
                bit_cnt_d = 4'd8;
            end
        end
    end

    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            flush_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            flush_q   <= flush_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {push_last, acc_q[7:0]};
        end
    end
endmodule

// File: tb/tb_turbo_puncture_packer.sv
// Bench for turbo_puncture_packer: a punctured and an unpunctured instance share
// stimulus, gated by sel; popped bytes are scored against an expected queue.
module tb_turbo_puncture_packer;
    logic       clk = 1'b0;
    logic       rst, sel;
    logic [2:0] sym_in;
    logic       sym_valid, sym_last, out_ready;

    logic       ready_p, last_p, valid_p, ready_u, last_u, valid_u;
    logic [7:0] byte_p, byte_u;
    logic       cur_ready, cur_last, cur_valid;
    logic [7:0] cur_byte;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    bit         bq[$];
    bit         ph;

    always #5 clk = ~clk;

    turbo_puncture_packer #(.FIFO_DEPTH(4), .PUNCTURE_EN(1'b1)) dut_p (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid & ~sel),
        .sym_last(sym_last), .sym_ready(ready_p), .out_byte(byte_p),
        .out_last(last_p), .out_valid(valid_p), .out_ready(out_ready & ~sel)
    );

    turbo_puncture_packer #(.FIFO_DEPTH(4), .PUNCTURE_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid & sel),
        .sym_last(sym_last), .sym_ready(ready_u), .out_byte(byte_u),
        .out_last(last_u), .out_valid(valid_u), .out_ready(out_ready & sel)
    );

    assign cur_ready = sel ? ready_u : ready_p;
    assign cur_byte  = sel ? byte_u  : byte_p;
    assign cur_last  = sel ? last_u  : last_p;
    assign cur_valid = sel ? valid_u : valid_p;

    typedef struct {
        bit         unp;
        int         nsym;
        logic [2:0] sym[8];
        int         nexp;
        logic [8:0] exp[4];
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every popped byte must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && cur_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {23'b0, cur_last, cur_byte}, 32'h1ff);
            end else begin
                check("out_byte_last", {23'b0, cur_last, cur_byte}, {23'b0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [2:0] gen(input int k);
        int v;
        v = k * 5 + 3;
        return v[2:0];
    endfunction

    // Punctured reference: sys then alternating parity1/parity2, packed LSB-first.
    task automatic model_punct(input logic [2:0] s);
        logic [7:0] b;
        bq.push_back(s[2]);
        bq.push_back(ph ? s[0] : s[1]);
        ph = ~ph;
        while (bq.size() >= 8) begin
            for (int i = 0; i < 8; i++) b[i] = bq.pop_front();
            exp_q.push_back({1'b0, b});
        end
    endtask

    task automatic send(input logic [2:0] s, input logic l);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        sym_in = s;
        sym_last = l;
        sym_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = cur_ready;
            @(posedge clk);
            #1;
            n++;
        end
        sym_valid = 1'b0;
        sym_last = 1'b0;
        check("send_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_bytes_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        sel = v.unp;
        out_ready = 1'b1;
        for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.exp[i]);
        for (int i = 0; i < v.nsym; i++) send(v.sym[i], i == v.nsym - 1);
        wait_drain();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_no_extra_byte", idx), {31'b0, cur_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 4, '{3'b101, 3'b011, 3'b110, 3'b000, 3'b0, 3'b0, 3'b0, 3'b0},
                    1, '{9'h139, 9'h0, 9'h0, 9'h0}};
        vecs[1] = '{1'b1, 3, '{3'b111, 3'b111, 3'b111, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0},
                    2, '{9'h0ff, 9'h101, 9'h0, 9'h0}};
        vecs[2] = '{1'b0, 1, '{3'b101, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0},
                    1, '{9'h101, 9'h0, 9'h0, 9'h0}};
        vecs[3] = '{1'b0, 1, '{3'b110, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0},
                    1, '{9'h103, 9'h0, 9'h0, 9'h0}};
        vecs[4] = '{1'b1, 8, '{3'b001, 3'b010, 3'b100, 3'b111, 3'b000, 3'b110, 3'b011, 3'b101},
                    3, '{9'h054, 9'h08e, 9'h1b9, 9'h0}};
        vecs[5] = '{1'b0, 5, '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b0, 3'b0, 3'b0},
                    2, '{9'h0ff, 9'h103, 9'h0, 9'h0}};
        vecs[6] = '{1'b0, 1, '{3'b000, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0},
                    1, '{9'h100, 9'h0, 9'h0, 9'h0}};

        rst = 1'b1; sel = 1'b0; sym_in = '0; sym_valid = 1'b0; sym_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, valid_p}, 32'd0);
        check("rst_out_byte", {24'b0, byte_p}, 32'd0);
        check("rst_out_last", {31'b0, last_p}, 32'd0);
        check("rst_sym_ready", {30'b0, ready_p, ready_u}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {30'b0, ready_p, ready_u}, 32'd3);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Backpressure: FIFO fills with 4 bytes, a 5th waits in the accumulator.
        sel = 1'b0;
        out_ready = 1'b0;
        ph = 1'b0;
        begin
            int k;
            k = 0;
            sym_valid = 1'b1;
            for (int c = 0; c < 60; c++) begin
                sym_in = gen(k);
                @(negedge clk);
                if (ready_p) begin
                    model_punct(gen(k));
                    k++;
                end
                @(posedge clk);
                #1;
            end
            sym_valid = 1'b0;
            check("bp_accepted", k, 32'd20);
        end
        @(negedge clk);
        check("bp_ready_low", {31'b0, ready_p}, 32'd0);
        check("bp_out_valid", {31'b0, valid_p}, 32'd1);
        @(posedge clk);
        #1;

        // One-cycle pop on a full FIFO with a byte pending.
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("pp_still_valid", {31'b0, valid_p}, 32'd1);
        check("pp_pending_pushed", {31'b0, ready_p}, 32'd1);
        @(posedge clk);
        #1;
        for (int k = 20; k < 24; k++) begin
            send(gen(k), 1'b0);
            model_punct(gen(k));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pp_fifo_still_full", {31'b0, ready_p}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("bp_resume_ready", {31'b0, ready_p}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-frame with two bytes queued and a partial byte in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 11; k++) send(gen(k), 1'b0);
        @(negedge clk);
        check("mid_queued_valid", {31'b0, valid_p}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, ready_p}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", {31'b0, valid_p}, 32'd0);
        check("mid_rst_out_byte", {24'b0, byte_p}, 32'd0);
        check("mid_rst_out_last", {31'b0, last_p}, 32'd0);
        check("mid_rst_ready_after", {31'b0, ready_p}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(9'h101);
        send(3'b101, 1'b1);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
